fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame and sends START, data LSB first, optional even parity, STOP.
// Define FIFO_UART_TX_PARITY_EN to compile in the PARITY state.
module fifo_uart_tx #(
  parameter int unsigned data_width   = 8,
  parameter int unsigned clks_per_bit = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  rempty,
  input  logic [data_width-1:0] r_data,
  output logic                  r_inc,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(clks_per_bit);
  localparam int unsigned IW = $clog2(data_width);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef FIFO_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_baud_cnt;
  logic [CW-1:0]         w_baud_nxt;
  logic [IW-1:0]         r_bit_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [data_width-1:0] r_shift;
  logic [data_width-1:0] w_shift_nxt;
  logic                  r_tx_out;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  w_baud_last;
  logic                  w_bit_last;
  logic                  w_pop;

`ifdef FIFO_UART_TX_PARITY_EN
  logic r_parity;
  logic w_par_nxt;

  function automatic logic even_parity(input logic [data_width-1:0] d);
    return ^d;
  endfunction
`endif

  assign w_baud_last = (r_baud_cnt == CW'(clks_per_bit - 1));
  assign w_bit_last  = (r_bit_idx == IW'(data_width - 1));
  // A pop is only allowed from IDLE or the final STOP cycle, and never while reset is held.
  assign w_pop  = !rst && tx_en && !rempty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));
  assign r_inc  = w_pop;
  assign tx_out = r_tx_out;
  assign busy   = r_busy;

  // Next-state, counter, shift-register and line-level computation.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx_out;
`ifdef FIFO_UART_TX_PARITY_EN
    w_par_nxt   = r_parity;
`endif
    if (w_pop) begin
      w_state_nxt = S_START;
      w_baud_nxt  = CW'(0);
      w_shift_nxt = r_data;
      w_tx_nxt    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      w_par_nxt   = even_parity(r_data);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tx_nxt   = 1'b1;
          w_baud_nxt = CW'(0);
        end
        S_START: begin
          if (w_baud_last) begin
            w_state_nxt = S_DATA;
            w_baud_nxt  = CW'(0);
            w_idx_nxt   = IW'(0);
            w_tx_nxt    = r_shift[0];
          end else begin
            w_baud_nxt = r_baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            w_baud_nxt = CW'(0);
            if (w_bit_last) begin
`ifdef FIFO_UART_TX_PARITY_EN
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_parity;
`else
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
`endif
            end else begin
              w_idx_nxt   = r_bit_idx + IW'(1);
              w_shift_nxt = r_shift >> 1;
              w_tx_nxt    = r_shift[1];
            end
          end else begin
            w_baud_nxt = r_baud_cnt + CW'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_last) begin
            w_state_nxt = S_STOP;
            w_baud_nxt  = CW'(0);
            w_tx_nxt    = 1'b1;
          end else begin
            w_baud_nxt = r_baud_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          // Reaching here on the last cycle means no pop: fall back to IDLE.
          if (w_baud_last) begin
            w_state_nxt = S_IDLE;
            w_baud_nxt  = CW'(0);
            w_tx_nxt    = 1'b1;
          end else begin
            w_baud_nxt = r_baud_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = CW'(0);
          w_tx_nxt    = 1'b1;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= CW'(0);
      r_bit_idx  <= IW'(0);
      r_shift    <= {data_width{1'b0}};
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_out   <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with clks_per_bit=4, data_width=8 and a small FIFO model.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       rempty;
  logic [7:0] r_data;
  logic       r_inc;
  logic       tx_out;
  logic       busy;

  logic [7:0] mem [0:15];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;

  int n_chk = 0;
  int n_err = 0;

  fifo_uart_tx #(.data_width(8), .clks_per_bit(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_en  (tx_en),
    .rempty (rempty),
    .r_data (r_data),
    .r_inc  (r_inc),
    .tx_out (tx_out),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rempty = (rd_ptr == wr_ptr);
  assign r_data = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (r_inc) rd_ptr <= rd_ptr + 5'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Samples one full frame on negedges; optional tx_en drop after sample drop_at.
  task automatic run_frame(input logic [7:0] d, input logic exp_pop, input int drop_at);
    for (int i = 0; i < NBITS * CPB; i++) begin
      @(negedge clk);
      check($sformatf("tx_%02h_s%0d", d, i), tx_out, exp_bit(d, i / CPB));
      check($sformatf("busy_%02h_s%0d", d, i), busy, 1'b1);
      if (i == NBITS * CPB - 1) check($sformatf("rinc_end_%02h", d), r_inc, exp_pop);
      else check($sformatf("rinc_mid_%02h_s%0d", d, i), r_inc, 1'b0);
      if (i == drop_at) tx_en = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_tx"}, tx_out, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rinc"}, r_inc, 1'b0);
  endtask

  initial begin
    int n_rinc;
    int n_busy;
    int n_low;
    rst   = 1'b0;
    tx_en = 1'b1;
    #1 rst = 1'b1;
    push(8'hA5);
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rinc", r_inc, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_hold_rinc", r_inc, 1'b0);
    rst = 1'b0;
    #1 check("first_pop", r_inc, 1'b1);
    run_frame(8'hA5, 1'b0, -1);
    check_idle("after_a5");

    push(8'h00);
    push(8'hFF);
    #1 check("b2b_pop1", r_inc, 1'b1);
    run_frame(8'h00, 1'b1, -1);
    run_frame(8'hFF, 1'b0, -1);
    check_idle("after_b2b");

    n_rinc = 0;
    n_busy = 0;
    n_low  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r_inc) n_rinc++;
      if (busy) n_busy++;
      if (!tx_out) n_low++;
    end
    check("empty_rinc_cnt", n_rinc, 0);
    check("empty_busy_cnt", n_busy, 0);
    check("empty_txlow_cnt", n_low, 0);

    push(8'h3C);
    push(8'h5A);
    #1 check("en_drop_pop", r_inc, 1'b1);
    run_frame(8'h3C, 1'b0, 10);
    n_rinc = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_inc) n_rinc++;
      if (busy) n_busy++;
    end
    check("en_drop_rinc_cnt", n_rinc, 0);
    check("en_drop_busy_cnt", n_busy, 0);

    push(8'h77);
    tx_en = 1'b1;
    #1 check("midrst_pop", r_inc, 1'b1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    check("midrst_data_bit1", tx_out, 1'b1);
    check("midrst_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rinc", r_inc, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_next_pop", r_inc, 1'b1);
    run_frame(8'h77, 1'b0, -1);
    check_idle("after_77");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
